// File: rtl/el2_pkg.sv
// Shared types for the DCCM SRAM sink: init sequencer state encoding.
package el2_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } el2_sram_init_state_e;

endpackage

// File: rtl/el2_sram_bank.sv
// One DCCM bank: synchronous single-port word array with a registered read
// port that holds its value whenever no read is issued.
module el2_sram_bank
  import el2_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 39
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [WORD_W-1:0] rd_xor,
  output logic [WORD_W-1:0] rd_word
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_p1;

  // The array itself is not reset; the init sequencer clears it by writing.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_word;
  end

  // Stage p0 -> p1: read register, loaded only on a read so it holds otherwise
  always_ff @(posedge clk) begin
    if (rst)        rd_p1 <= '0;
    else if (rd_en) rd_p1 <= mem[addr] ^ rd_xor;
  end

  assign rd_word = rd_p1;

endmodule

// File: rtl/el2_dccm_sram_sink.sv
// DCCM SRAM responder: per-bank arrays, post-reset clearing sequencer, and an
// optional one-shot read-corruption injector enabled by EL2_SRAM_ERR_INJ_EN.
module el2_dccm_sram_sink
  import el2_pkg::*;
#(
  parameter int               NUM_BANKS = 4,
  parameter int               ADDR_W    = 10,
  parameter int               DATA_W    = 32,
  parameter int               ECC_W     = 7,
  parameter logic [ECC_W-1:0] INIT_ECC  = 7'h00
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_BANKS-1:0]                dccm_clken,
  input  logic [NUM_BANKS-1:0]                dccm_wren_bank,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0]    dccm_addr_bank,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]    dccm_wr_data_bank,
  input  logic [NUM_BANKS-1:0][ECC_W-1:0]     dccm_wr_ecc_bank,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]    dccm_bank_dout,
  output logic [NUM_BANKS-1:0][ECC_W-1:0]     dccm_bank_ecc,
  output logic                                init_done
`ifdef EL2_SRAM_ERR_INJ_EN
  ,
  input  logic                                inj_req,
  input  logic [$clog2(NUM_BANKS)-1:0]        inj_bank,
  input  logic [DATA_W+ECC_W-1:0]             inj_mask,
  output logic                                inj_ack
`endif
);

  localparam int WORD_W = DATA_W + ECC_W;
  localparam int BANK_W = $clog2(NUM_BANKS);

  el2_sram_init_state_e state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic                 init_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt wraps back to 0 on the last init write and then stays parked.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = READY;
    end
  end

  assign init_active = (state_q == INIT);
  assign init_done   = (state_q == READY);

  logic [NUM_BANKS-1:0]             bank_wr_en;
  logic [NUM_BANKS-1:0]             bank_rd_en;
  logic [NUM_BANKS-1:0][ADDR_W-1:0] bank_addr;
  logic [NUM_BANKS-1:0][WORD_W-1:0] bank_wr_word;
  logic [NUM_BANKS-1:0][WORD_W-1:0] bank_rd_xor;
  logic [NUM_BANKS-1:0][WORD_W-1:0] bank_rd_word;

`ifdef EL2_SRAM_ERR_INJ_EN
  logic              inj_pend_q;
  logic [BANK_W-1:0] inj_bank_q;
  logic [WORD_W-1:0] inj_mask_q;
  logic              inj_ack_q;
  logic              inj_arm;
  logic [NUM_BANKS-1:0] inj_hit;

  assign inj_arm = init_done & inj_req;

  // A new request overrides a still-pending one; arming wins over consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_pend_q <= 1'b0;
      inj_ack_q  <= 1'b0;
    end else begin
      inj_ack_q <= inj_arm;
      if (inj_arm)       inj_pend_q <= 1'b1;
      else if (|inj_hit) inj_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (inj_arm) begin
      inj_bank_q <= inj_bank;
      inj_mask_q <= inj_mask;
    end
  end

  assign inj_ack = inj_ack_q;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    // Init sequencer owns every bank port until the clear sweep completes.
    assign bank_wr_en[b]   = init_active | (dccm_clken[b] & dccm_wren_bank[b]);
    assign bank_rd_en[b]   = ~init_active & dccm_clken[b] & ~dccm_wren_bank[b];
    assign bank_addr[b]    = init_active ? cnt_q : dccm_addr_bank[b];
    assign bank_wr_word[b] = init_active ? {{DATA_W{1'b0}}, INIT_ECC}
                                         : {dccm_wr_data_bank[b], dccm_wr_ecc_bank[b]};

`ifdef EL2_SRAM_ERR_INJ_EN
    logic inj_sel;
    assign inj_sel        = inj_pend_q && (inj_bank_q == BANK_W'(b));
    assign inj_hit[b]     = inj_sel & bank_rd_en[b];
    assign bank_rd_xor[b] = inj_sel ? inj_mask_q : '0;
`else
    assign bank_rd_xor[b] = '0;
`endif

    el2_sram_bank #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bank_wr_en[b]),
      .rd_en   (bank_rd_en[b]),
      .addr    (bank_addr[b]),
      .wr_word (bank_wr_word[b]),
      .rd_xor  (bank_rd_xor[b]),
      .rd_word (bank_rd_word[b])
    );

    assign dccm_bank_dout[b] = bank_rd_word[b][WORD_W-1:ECC_W];
    assign dccm_bank_ecc[b]  = bank_rd_word[b][ECC_W-1:0];
  end

endmodule
